// File: rtl/stop_watch_pkg.sv
// Shared definitions for the parametrised BCD stopwatch: digit moduli and
// the run-state encoding used by the core.
package stop_watch_pkg;

  localparam int DEC_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } run_state_t;

  // Digit 2 is tens of seconds; every other digit is plain decimal.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 2) ? 4'(SEC_TENS_MAX) : 4'(DEC_MAX);
  endfunction

endpackage

// File: rtl/param_stop_watch_if.sv
// Control/display bundle between the stopwatch core (slave) and whatever
// drives its buttons and reads its digits (master).
interface param_stop_watch_if #(
  parameter int N_DIGITS = 4
);

  logic                  go;
  logic                  back;
  logic                  clr;
  logic                  lap;
  logic [4*N_DIGITS-1:0] bcd;
  logic                  running;
  logic                  at_zero;
  logic                  ovf;
  logic                  lap_active;

  modport master (
    output go, back, clr, lap,
    input  bcd, running, at_zero, ovf, lap_active
  );

  modport slave (
    input  go, back, clr, lap,
    output bcd, running, at_zero, ovf, lap_active
  );

endinterface

// File: rtl/sw_bcd_digit.sv
// One BCD digit with programmable top value; counts up or down when enabled
// and flags the carry/borrow that enables the next digit.
module sw_bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       down,
  input  logic [3:0] max,
  output logic [3:0] digit,
  output logic       co
);

  logic [3:0] digit_reg;

  assign co    = en & (down ? (digit_reg == 4'd0) : (digit_reg == max));
  assign digit = digit_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      digit_reg <= 4'd0;
    end else if (en) begin
      if (down) begin
        digit_reg <= (digit_reg == 4'd0) ? max : digit_reg - 4'd1;
      end else begin
        digit_reg <= (digit_reg == max) ? 4'd0 : digit_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/param_stop_watch.sv
// Parametrised BCD stopwatch core: run/pause/stop FSM, tick prescaler and a
// rippled digit chain. Lap-hold display is built only with PARAM_STOP_WATCH_LAP_EN.
module param_stop_watch
  import stop_watch_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 10_000_000
) (
  input logic               clk,
  input logic               reset,
  param_stop_watch_if.slave sw
);

  localparam int CW = 4 * N_DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  run_state_t      state_reg;
  logic [PW-1:0]   presc_reg;
  logic            go_d_reg;
  logic            go_rise_reg;
  logic            armed_reg;
  logic            ovf_reg;
  logic            at_zero_reg;

  logic [CW-1:0]       count;
  logic [N_DIGITS-1:0] en;
  logic [N_DIGITS-1:0] co;
  logic                down;
  logic                tick;
  logic                step;
  logic                wrap;
  logic                count_is_zero;
  logic                lands_zero;

  assign down          = sw.back;
  assign tick          = (state_reg == RUN) && (presc_reg == PRESC_LAST);
  assign count_is_zero = (count == '0);
  assign lands_zero    = (count == CW'(1));
  // A down tick at zero must not borrow the chain round to the maximum.
  assign step          = tick & ~(down & count_is_zero);
  assign wrap          = step & ~down & co[N_DIGITS-1];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign en[gi] = step;
      end else begin : g_chain
        assign en[gi] = co[gi-1];
      end

      sw_bcd_digit u_digit (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clr),
        .en    (en[gi]),
        .down  (down),
        .max   (digit_max(gi)),
        .digit (count[4*gi +: 4]),
        .co    (co[gi])
      );
    end
  endgenerate

  // Edge detection is held off for the first cycle after reset so a button
  // already held during reset does not register as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_d_reg    <= 1'b0;
      go_rise_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      go_d_reg    <= sw.go;
      go_rise_reg <= sw.go & ~go_d_reg & armed_reg & ~sw.clr;
      armed_reg   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sw.clr) begin
      state_reg   <= STOP;
      presc_reg   <= '0;
      ovf_reg     <= 1'b0;
      at_zero_reg <= 1'b1;
    end else begin
      ovf_reg <= wrap;
      if (step) begin
        at_zero_reg <= down ? lands_zero : wrap;
      end
      case (state_reg)
        STOP: begin
          presc_reg <= '0;
          if (go_rise_reg) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          presc_reg <= tick ? '0 : presc_reg + PW'(1);
          if (go_rise_reg) begin
            state_reg <= PAUSE;
          end else if (tick && down && (count_is_zero || lands_zero)) begin
            state_reg <= STOP;
          end
        end
        PAUSE: begin
          if (go_rise_reg) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= STOP;
      endcase
    end
  end

  assign sw.running = (state_reg == RUN);
  assign sw.at_zero = at_zero_reg;
  assign sw.ovf     = ovf_reg;

`ifdef PARAM_STOP_WATCH_LAP_EN
  logic          lap_d_reg;
  logic          lap_rise_reg;
  logic          lap_active_reg;
  logic [CW-1:0] snap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_d_reg      <= 1'b0;
      lap_rise_reg   <= 1'b0;
      lap_active_reg <= 1'b0;
      snap_reg       <= '0;
    end else begin
      lap_d_reg    <= sw.lap;
      lap_rise_reg <= sw.lap & ~lap_d_reg & armed_reg & ~sw.clr;
      if (sw.clr) begin
        lap_active_reg <= 1'b0;
      end else if (lap_rise_reg) begin
        lap_active_reg <= ~lap_active_reg;
        if (!lap_active_reg) begin
          snap_reg <= count;
        end
      end
    end
  end

  assign sw.bcd        = lap_active_reg ? snap_reg : count;
  assign sw.lap_active = lap_active_reg;
`else
  logic unused_lap;
  assign unused_lap    = sw.lap;
  assign sw.bcd        = count;
  assign sw.lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_param_stop_watch.sv
// Scoreboard bench for param_stop_watch: the stimulus side steps a time-value
// reference model and queues expected outputs; a monitor compares each cycle.
module tb_param_stop_watch;

  localparam int N    = 4;
  localparam int TD   = 4;
  localparam int MAXV = 600 * (10 ** (N - 3));

  typedef struct packed {
    logic [4*N-1:0] bcd;
    logic           running;
    logic           at_zero;
    logic           ovf;
    logic           lap_active;
  } exp_t;

  logic clk;
  logic reset;
  param_stop_watch_if #(.N_DIGITS(N)) sw ();

  param_stop_watch #(.N_DIGITS(N), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t e;

  // Reference model: elapsed time kept as an integer number of tenths.
  int m_v, m_phase, m_snap;
  bit m_run, m_pause, m_ovf, m_lap_on;
  bit m_go_prev, m_lap_prev, m_armed, m_go_pend, m_lap_pend;

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int q;
    r = '0;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 6);
    q = v / 600;
    for (int i = 3; i < N; i++) begin
      r[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit g, input bit b, input bit c, input bit l);
    bit tick, hit_zero;
    int nv;
    if (r) begin
      m_v = 0; m_phase = 0; m_snap = 0; m_run = 0; m_pause = 0; m_ovf = 0;
      m_lap_on = 0; m_go_prev = 0; m_lap_prev = 0; m_armed = 0;
      m_go_pend = 0; m_lap_pend = 0;
      return;
    end
    tick     = m_run && (m_phase == TD - 1);
    nv       = m_v;
    hit_zero = 0;
    m_ovf    = 0;
    if (c) begin
      nv = 0; m_run = 0; m_pause = 0; m_phase = 0; m_lap_on = 0;
    end else begin
      if (tick) begin
        if (!b) begin
          if (m_v == MAXV - 1) begin
            nv = 0; m_ovf = 1;
          end else begin
            nv = m_v + 1;
          end
        end else if (m_v == 0) begin
          hit_zero = 1;
        end else begin
          nv = m_v - 1;
          hit_zero = (nv == 0);
        end
      end
      if (m_run) m_phase = tick ? 0 : m_phase + 1;
      else if (!m_pause) m_phase = 0;
      if (m_go_pend) begin
        if (m_run) begin m_run = 0; m_pause = 1; end
        else begin m_run = 1; m_pause = 0; end
      end else if (m_run && hit_zero) begin
        m_run = 0;
      end
`ifdef PARAM_STOP_WATCH_LAP_EN
      if (m_lap_pend) begin
        if (!m_lap_on) m_snap = m_v;
        m_lap_on = !m_lap_on;
      end
`endif
    end
    m_go_pend  = g && !m_go_prev && m_armed && !c;
    m_lap_pend = l && !m_lap_prev && m_armed && !c;
    m_go_prev  = g;
    m_lap_prev = l;
    m_armed    = 1;
    m_v        = nv;
  endtask

  // One clock cycle of stimulus; the expected post-edge outputs are queued.
  task automatic cyc(input bit r, input bit g, input bit b, input bit c, input bit l);
    exp_t x;
    reset = r; sw.go = g; sw.back = b; sw.clr = c; sw.lap = l;
    @(posedge clk);
    model_edge(r, g, b, c, l);
    x.bcd        = m_lap_on ? to_bcd(m_snap) : to_bcd(m_v);
    x.running    = m_run;
    x.at_zero    = (m_v == 0);
    x.ovf        = m_ovf;
    x.lap_active = m_lap_on;
    exp_q.push_back(x);
    #1;
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(0, 0, b, 0, 0);
  endtask

  task automatic chk(input string name, input logic [4*N-1:0] act, input logic [4*N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bcd",        sw.bcd,                  e.bcd);
      chk("running",    {15'd0, sw.running},     {15'd0, e.running});
      chk("at_zero",    {15'd0, sw.at_zero},     {15'd0, e.at_zero});
      chk("ovf",        {15'd0, sw.ovf},         {15'd0, e.ovf});
      chk("lap_active", {15'd0, sw.lap_active},  {15'd0, e.lap_active});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rb, rg, rc, rl, rr;
    reset = 1'b1; sw.go = 1'b0; sw.back = 1'b0; sw.clr = 1'b0; sw.lap = 1'b0;

    // Reset with go already high: no start on release.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(3, 0);
    $display("step reset: bcd=%h running=%0d", to_bcd(m_v), m_run);

    cyc(0, 1, 0, 0, 0);
    idle(41, 0);
    $display("step basic run: model value %0d tenths", m_v);

    for (int i = 0; i < 5000 && m_v != 599; i++) cyc(0, 0, 0, 0, 0);
    idle(8, 0);
    $display("step seconds carry: model value %0d", m_v);

    for (int i = 0; i < 30000 && m_v != MAXV - 1; i++) cyc(0, 0, 0, 0, 0);
    idle(8, 0);
    $display("step wrap: model value %0d", m_v);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 100 && m_v != 3; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 100 && m_run; i++) cyc(0, 0, 1, 0, 0);
    idle(5, 1);
    cyc(0, 1, 1, 0, 0);
    idle(12, 1);
    $display("step down to zero: model value %0d running %0d", m_v, m_run);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    idle(6, 0);
    for (int i = 0; i < 20 && !(m_run && m_phase == 2); i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(7, 0);
    cyc(0, 1, 0, 0, 0);
    idle(10, 0);
    $display("step pause/resume: model value %0d", m_v);

    cyc(0, 1, 0, 0, 0);
    idle(3, 0);
    cyc(0, 1, 0, 0, 0);
    idle(10, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    idle(6, 0);
    $display("step clr with go: running %0d", m_run);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 200 && m_v != 12; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    idle(5 * TD + 2, 0);
    cyc(0, 0, 0, 0, 1);
    idle(6, 0);
    cyc(0, 0, 0, 0, 1);
    idle(3, 0);
    cyc(0, 0, 0, 1, 0);
    idle(3, 0);
    $display("step lap: lap_active %0d model value %0d", m_lap_on, m_v);

    rb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) rb = !rb;
      rg = ($urandom_range(0, 5) == 0);
      rc = ($urandom_range(0, 149) == 0);
      rl = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 1999) == 0);
      cyc(rr, rg, rb, rc, rl);
    end
    $display("step random: model value %0d", m_v);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_stop_watch.md
# param_stop_watch

Parametrised BCD stopwatch core with run/pause, count direction, clear and lap-hold. It generalises the team's fixed 4-digit enhanced stopwatch to a configurable digit count and tick rate, and adds overflow, zero detection and lap display. It drives the flattened BCD digit bus into `disp_hex_mux`, or a wider display mux, in the board-level test wrappers.

## Interface

Parameters:
- `N_DIGITS`, 4: number of BCD digits, minimum 3.
- `TICK_DIV`, 10_000_000: clk cycles per 0.1 s tick, minimum 2.

Ports (clock and reset first). Single clock `clk`; reset `reset` is synchronous, active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous active-high reset.
- `go` in 1: debounced level; each rising edge toggles run/pause.
- `back` in 1: debounced level; 1 = count down, 0 = count up. Sampled at each tick.
- `clr` in 1: debounced level; clears the count and stops.
- `lap` in 1: debounced level; each rising edge toggles lap-hold.
- `bcd` out 4*N_DIGITS: displayed digits, packed as digit i at bits [4i+3:4i].
- `running` out 1: run state.
- `at_zero` out 1: live count equals zero.
- `ovf` out 1: one-cycle pulse when an up-count wraps.
- `lap_active` out 1: display is frozen.

## Operation

- Digit moduli:
  - d0: 0.1 s, 0–9.
  - d1: seconds, 0–9.
  - d2: tens of seconds, 0–5.
  - d3 and above: minutes and tens of minutes, each 0–9.
- Max count is 9…9 5 9 9, with d2 = 5 and all other digits = 9.
- Run FSM states:
  - STOP, entered from reset or `clr`.
  - RUN.
  - PAUSE.
- Run FSM transitions:
  - `go` rise: STOP→RUN, RUN→PAUSE, PAUSE→RUN.
  - `clr` (level): any state→STOP.
  - Down-count reaching zero: RUN→STOP.
- `running` = 1 only in RUN.
- Prescaler counts 0..TICK_DIV-1 only in RUN. It holds its value in PAUSE and clears in STOP.
- Tick: prescaler == TICK_DIV-1 while in RUN. On the tick the prescaler wraps to 0 and the count steps once.
- Up step: ripple BCD increment with per-digit modulus. At max count, all digits wrap to 0 and `ovf` = 1 for that cycle; counting continues.
- Down step: ripple BCD decrement with borrow.
  - If the count is already 0: no change, FSM → STOP.
  - If the step lands on 0: FSM → STOP on the same edge.
- `at_zero` reflects the live count (not the lap snapshot), registered.
- `go` edge detection uses a registered copy of `go`; `lap` edge detection uses a registered copy of `lap`.

Priority, highest first:
1. `reset`.
2. `clr`.
3. `go` rise.
4. Tick.

Simultaneous events:
- `clr` together with a `go` rise: the `go` rise is discarded and the state stays STOP.
- `go` rise in RUN coinciding with a tick: the tick still applies, then PAUSE.
- Direction change mid-run: takes effect at the next tick. The prescaler is not disturbed.

## Timing

- Reset values, one edge after `reset` is sampled high:
  - count 0, prescaler 0, STOP.
  - `bcd` = 0, `running` = 0, `at_zero` = 1, `ovf` = 0, `lap_active` = 0.
  - Edge-detect registers = 0, so an input already high at reset release does not create an edge.
- `go` rise at edge k: `running` = 1 after edge k+1 (edge detect plus FSM register). The first tick comes TICK_DIV cycles later.
- Count step: `bcd` (unfrozen) updates on the edge that registers the tick. This gives exactly one step per TICK_DIV RUN cycles.
- `clr` asserted at edge k: count, prescaler and lap-hold are cleared after edge k. They stay cleared while `clr` is held.
- `ovf` is high for exactly one cycle, aligned with the wrap.

## Configuration

- `PARAM_STOP_WATCH_LAP_EN` defined:
  - A lap rise latches the live count into a snapshot and sets `lap_active`; `bcd` shows the snapshot.
  - The next lap rise clears `lap_active` and `bcd` returns to the live count.
  - The live count runs unaffected throughout.
  - `clr` also clears `lap_active`.
- Not defined:
  - `lap` is ignored, `lap_active` is tied to 0, and `bcd` always shows the live count.
  - No snapshot register is built.

## Structure

- Shared package `stop_watch_pkg` holds:
  - digit modulus constants (DEC_MAX = 9, SEC_TENS_MAX = 5);
  - the run FSM state encoding (STOP, RUN, PAUSE);
  - a function giving the modulus of digit index i.
- One sub-module, `sw_bcd_digit`: a single-digit BCD up/down counter.
  - Inputs: `clk`, `reset`, `clr`, enable, direction, max.
  - Outputs: digit, carry/borrow out.
  - The core instantiates it N_DIGITS times in a generate loop, chaining carry/borrow to the next digit's enable.

## Test plan

Bench uses N_DIGITS = 4, TICK_DIV = 4.

1. Reset then `go` pulse, 40 RUN cycles → `bcd` = 0x0010, `running` = 1, `at_zero` = 0.
2. Preload to 0x0599 by running, then one tick → 0x1000. Preload to 0x9599, then one tick → 0x0000 with a single-cycle `ovf`.
3. Count from 0x0003 with `back` = 1, 3 ticks → 0x0000, `running` falls on the same edge, `at_zero` = 1. Further `go` rise in STOP with `back` = 1 → no change below 0.
4. `go` rise mid-prescaler (prescaler = 2) → PAUSE holds prescaler; second `go` rise → the next tick arrives after 2 RUN cycles.
5. `clr` and `go` rise in the same cycle while RUN → STOP, `bcd` = 0, `running` = 0. Releasing `clr` with `go` still high → no spurious start.
6. With `PARAM_STOP_WATCH_LAP_EN`: lap rise at 0x0012 → `bcd` holds 0x0012 while the live count advances 5 ticks. Second lap rise → `bcd` = 0x0017. Without the macro: `bcd` tracks live, `lap_active` = 0.
